// File: rtl/in_order_accept.sv
// Receive-side RC sequence checker: classifies packets against the per-QP EPSN, forwards in-order traffic, drops the rest, emits ACK/NAK.
// Optional INORDER_ACCEPT_NAK_ONCE_EN: suppress repeated NAKs per QP until an in-order packet arrives.
`ifndef PKT_HEAD_WIDTH
`define PKT_HEAD_WIDTH 320
`endif
`ifndef PKT_DATA_WIDTH
`define PKT_DATA_WIDTH 256
`endif
`ifndef QP_NUM_LOG
`define QP_NUM_LOG 4
`endif
`ifndef PSN_WIDTH
`define PSN_WIDTH 24
`endif
`ifndef QPN_OFFSET
`define QPN_OFFSET 224
`endif
`ifndef SERVICE_TYPE_OFFSET
`define SERVICE_TYPE_OFFSET 216
`endif

module in_order_accept #(
  parameter int HEAD_W    = `PKT_HEAD_WIDTH,
  parameter int DATA_W    = `PKT_DATA_WIDTH,
  parameter int QPN_LOG   = `QP_NUM_LOG,
  parameter int PSN_W     = `PSN_WIDTH,
  parameter int ACK_CMD_W = 50,
  parameter int QPN_OFS   = `QPN_OFFSET,
  parameter int SVC_OFS   = `SERVICE_TYPE_OFFSET
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_packet_in_valid,
  input  logic [HEAD_W-1:0]    iv_packet_in_head,
  input  logic [DATA_W-1:0]    iv_packet_in_data,
  input  logic                 i_packet_in_start,
  input  logic                 i_packet_in_last,
  output logic                 o_packet_in_ready,
  output logic [QPN_LOG-1:0]   ov_epsn_rd_index,
  input  logic [PSN_W-1:0]     iv_epsn_rd_data,
  output logic                 o_epsn_wr_en,
  output logic [QPN_LOG-1:0]   ov_epsn_wr_index,
  output logic [PSN_W-1:0]     ov_epsn_wr_data,
  output logic                 o_ack_wr_en,
  output logic [ACK_CMD_W-1:0] ov_ack_din,
  input  logic                 i_ack_prog_full,
  output logic                 o_packet_out_valid,
  output logic [HEAD_W-1:0]    ov_packet_out_head,
  output logic [DATA_W-1:0]    ov_packet_out_data,
  output logic                 o_packet_out_start,
  output logic                 o_packet_out_last,
  input  logic                 i_packet_out_ready,
  output logic [31:0]          ov_dup_cnt,
  output logic [31:0]          ov_oos_cnt
);

  localparam logic [2:0] SVC_RC = 3'd0;
  localparam logic [2:0] SVC_UC = 3'd1;
  localparam logic [2:0] SVC_UD = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_e;
  typedef enum logic [2:0] {C_INORDER, C_OOS, C_DUP, C_UC, C_UD, C_OTHER} cls_e;

  state_e               state_q, state_d;
  cls_e                 cls_q, cls_d, cls_new;
  logic [23:0]          qpn_q, qpn_d;
  logic [PSN_W-1:0]     psn_q, psn_d, epsn_q, epsn_d;
  logic                 ack_wr_en_q, ack_wr_en_d;
  logic [ACK_CMD_W-1:0] ack_din_q, ack_din_d;
  logic [31:0]          dup_cnt_q, dup_cnt_d, oos_cnt_q, oos_cnt_d;
  logic                 last_hs;
`ifdef INORDER_ACCEPT_NAK_ONCE_EN
  logic [(1<<QPN_LOG)-1:0] nak_sent_q, nak_sent_d;
`endif

  logic [PSN_W-1:0]   hdr_psn, psn_diff;
  logic [23:0]        hdr_qpn;
  logic [2:0]         hdr_svc;
  logic [QPN_LOG-1:0] qpn_idx;

  assign hdr_psn  = iv_packet_in_head[271:248];
  assign hdr_qpn  = iv_packet_in_head[QPN_OFS +: 24];
  assign hdr_svc  = iv_packet_in_head[SVC_OFS +: 3];
  assign psn_diff = hdr_psn - iv_epsn_rd_data;
  assign qpn_idx  = qpn_q[QPN_LOG-1:0];

  assign ov_epsn_rd_index = (state_q == S_IDLE) ? hdr_qpn[QPN_LOG-1:0] : qpn_idx;
  assign o_ack_wr_en      = ack_wr_en_q;
  assign ov_ack_din       = ack_din_q;
  assign ov_dup_cnt       = dup_cnt_q;
  assign ov_oos_cnt       = oos_cnt_q;

  // Forward distance below half the PSN space is a gap; anything else is a retransmission.
  always_comb begin
    cls_new = C_OTHER;
    if (hdr_svc == SVC_RC) begin
      if (psn_diff == '0)               cls_new = C_INORDER;
      else if (!psn_diff[PSN_W-1])      cls_new = C_OOS;
      else                              cls_new = C_DUP;
    end else if (hdr_svc == SVC_UC) begin
      cls_new = C_UC;
    end else if (hdr_svc == SVC_UD) begin
      cls_new = C_UD;
    end
  end

  always_comb begin
    state_d            = state_q;
    cls_d              = cls_q;
    qpn_d              = qpn_q;
    psn_d              = psn_q;
    epsn_d             = epsn_q;
    ack_wr_en_d        = 1'b0;
    ack_din_d          = '0;
    dup_cnt_d          = dup_cnt_q;
    oos_cnt_d          = oos_cnt_q;
    o_packet_in_ready  = 1'b0;
    o_packet_out_valid = 1'b0;
    ov_packet_out_head = '0;
    ov_packet_out_data = '0;
    o_packet_out_start = 1'b0;
    o_packet_out_last  = 1'b0;
    o_epsn_wr_en       = 1'b0;
    ov_epsn_wr_index   = '0;
    ov_epsn_wr_data    = '0;
    last_hs            = 1'b0;
`ifdef INORDER_ACCEPT_NAK_ONCE_EN
    nak_sent_d         = nak_sent_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_packet_in_valid && i_packet_in_start && !i_ack_prog_full) begin
          qpn_d   = hdr_qpn;
          psn_d   = hdr_psn;
          epsn_d  = iv_epsn_rd_data;
          cls_d   = cls_new;
          state_d = (cls_new == C_INORDER || cls_new == C_UC || cls_new == C_UD) ? S_FWD : S_DROP;
        end
      end
      S_FWD: begin
        o_packet_in_ready  = i_packet_out_ready;
        o_packet_out_valid = i_packet_in_valid && i_packet_out_ready;
        ov_packet_out_data = iv_packet_in_data;
        o_packet_out_start = i_packet_in_start;
        o_packet_out_last  = i_packet_in_last;
        // Strip the 3-byte PSN field and shorten the header length to match.
        if (i_packet_in_start) begin
          ov_packet_out_head[247:8] = iv_packet_in_head[247:8];
          ov_packet_out_head[7:0]   = iv_packet_in_head[7:0] - 8'd3;
        end
        last_hs = i_packet_in_valid && i_packet_out_ready && i_packet_in_last;
      end
      S_DROP: begin
        o_packet_in_ready = 1'b1;
        last_hs           = i_packet_in_valid && i_packet_in_last;
      end
      default: state_d = S_IDLE;
    endcase

    if (last_hs) begin
      state_d = S_IDLE;
      unique case (cls_q)
        C_INORDER: begin
          o_epsn_wr_en     = 1'b1;
          ov_epsn_wr_index = qpn_idx;
          ov_epsn_wr_data  = psn_q + PSN_W'(1);
          ack_wr_en_d      = 1'b1;
          ack_din_d        = {2'b01, psn_q, qpn_q};
`ifdef INORDER_ACCEPT_NAK_ONCE_EN
          nak_sent_d[qpn_idx] = 1'b0;
`endif
        end
        C_UC: begin
          o_epsn_wr_en     = 1'b1;
          ov_epsn_wr_index = qpn_idx;
          ov_epsn_wr_data  = psn_q + PSN_W'(1);
        end
        C_DUP: begin
          ack_wr_en_d = 1'b1;
          ack_din_d   = {2'b01, epsn_q - PSN_W'(1), qpn_q};
          if (dup_cnt_q != '1) dup_cnt_d = dup_cnt_q + 32'd1;
        end
        C_OOS: begin
          if (oos_cnt_q != '1) oos_cnt_d = oos_cnt_q + 32'd1;
`ifdef INORDER_ACCEPT_NAK_ONCE_EN
          if (!nak_sent_q[qpn_idx]) begin
            ack_wr_en_d         = 1'b1;
            ack_din_d           = {2'b10, epsn_q, qpn_q};
            nak_sent_d[qpn_idx] = 1'b1;
          end
`else
          ack_wr_en_d = 1'b1;
          ack_din_d   = {2'b10, epsn_q, qpn_q};
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cls_q       <= C_INORDER;
      qpn_q       <= '0;
      psn_q       <= '0;
      epsn_q      <= '0;
      ack_wr_en_q <= 1'b0;
      ack_din_q   <= '0;
      dup_cnt_q   <= '0;
      oos_cnt_q   <= '0;
`ifdef INORDER_ACCEPT_NAK_ONCE_EN
      nak_sent_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      qpn_q       <= qpn_d;
      psn_q       <= psn_d;
      epsn_q      <= epsn_d;
      ack_wr_en_q <= ack_wr_en_d;
      ack_din_q   <= ack_din_d;
      dup_cnt_q   <= dup_cnt_d;
      oos_cnt_q   <= oos_cnt_d;
`ifdef INORDER_ACCEPT_NAK_ONCE_EN
      nak_sent_q  <= nak_sent_d;
`endif
    end
  end

endmodule

// File: tb/tb_in_order_accept.sv
// Bench for in_order_accept: queue-based expectation model plus an every-cycle compare process and literal spot checks.
module tb_in_order_accept;
  localparam int HEAD_W = 320, DATA_W = 64, QPN_LOG = 4, PSN_W = 24, ACK_W = 50;
  localparam int QPN_OFS = 224, SVC_OFS = 216;
  localparam logic [2:0] RC = 3'd0, UC = 3'd1, RD = 3'd2, UD = 3'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic i_packet_in_valid, i_packet_in_start, i_packet_in_last, o_packet_in_ready;
  logic [HEAD_W-1:0] iv_packet_in_head, ov_packet_out_head;
  logic [DATA_W-1:0] iv_packet_in_data, ov_packet_out_data;
  logic [QPN_LOG-1:0] ov_epsn_rd_index, ov_epsn_wr_index;
  logic [PSN_W-1:0] iv_epsn_rd_data, ov_epsn_wr_data;
  logic o_epsn_wr_en, o_ack_wr_en, i_ack_prog_full;
  logic [ACK_W-1:0] ov_ack_din;
  logic o_packet_out_valid, o_packet_out_start, o_packet_out_last, i_packet_out_ready;
  logic [31:0] ov_dup_cnt, ov_oos_cnt;

  in_order_accept #(.HEAD_W(HEAD_W), .DATA_W(DATA_W), .QPN_LOG(QPN_LOG), .PSN_W(PSN_W),
                    .ACK_CMD_W(ACK_W), .QPN_OFS(QPN_OFS), .SVC_OFS(SVC_OFS)) dut (
    .clk(clk), .rst(rst),
    .i_packet_in_valid(i_packet_in_valid), .iv_packet_in_head(iv_packet_in_head),
    .iv_packet_in_data(iv_packet_in_data), .i_packet_in_start(i_packet_in_start),
    .i_packet_in_last(i_packet_in_last), .o_packet_in_ready(o_packet_in_ready),
    .ov_epsn_rd_index(ov_epsn_rd_index), .iv_epsn_rd_data(iv_epsn_rd_data),
    .o_epsn_wr_en(o_epsn_wr_en), .ov_epsn_wr_index(ov_epsn_wr_index), .ov_epsn_wr_data(ov_epsn_wr_data),
    .o_ack_wr_en(o_ack_wr_en), .ov_ack_din(ov_ack_din), .i_ack_prog_full(i_ack_prog_full),
    .o_packet_out_valid(o_packet_out_valid), .ov_packet_out_head(ov_packet_out_head),
    .ov_packet_out_data(ov_packet_out_data), .o_packet_out_start(o_packet_out_start),
    .o_packet_out_last(o_packet_out_last), .i_packet_out_ready(i_packet_out_ready),
    .ov_dup_cnt(ov_dup_cnt), .ov_oos_cnt(ov_oos_cnt)
  );

  // EPSN table owned by the environment; the DUT writes it, the bench seeds it.
  logic [23:0] epsn_mem [16];
  logic tb_wr = 1'b0;
  logic [3:0] tb_idx = '0;
  logic [23:0] tb_data = '0;
  assign iv_epsn_rd_data = epsn_mem[ov_epsn_rd_index];
  always @(posedge clk) begin
    if (o_epsn_wr_en) epsn_mem[ov_epsn_wr_index] <= ov_epsn_wr_data;
    else if (tb_wr)   epsn_mem[tb_idx] <= tb_data;
  end

  int n_chk = 0, n_pass = 0;
  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct { bit wr; logic [3:0] idx; logic [23:0] wdata; bit ack; logic [49:0] ackv; bit dup; bit oos; } pkt_rec_t;
  typedef struct { logic [HEAD_W-1:0] head; logic [DATA_W-1:0] data; bit s; bit l; } beat_t;
  pkt_rec_t pkt_q[$];
  beat_t    beat_q[$];

  // Model state owned by the stimulus thread
  logic [23:0] m_epsn [16];
  bit [15:0] m_nak = '0;
  int pkt_id = 0;

  // Model state owned by the compare process
  bit chk_en = 1'b0;
  bit pend_ack = 1'b0;
  logic [49:0] pend_ackv = '0;
  logic [31:0] m_dup = '0, m_oos = '0;
  int nak_seen = 0;
  logic [49:0] last_ack = '0;
  logic [7:0] last_head_lo = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit lhs;
      pkt_rec_t r;
      beat_t b;
      check(o_ack_wr_en === pend_ack, "ack_wr_en", 64'(o_ack_wr_en), 64'(pend_ack));
      if (pend_ack) check(ov_ack_din === pend_ackv, "ack_din", 64'(ov_ack_din), 64'(pend_ackv));
      if (o_ack_wr_en === 1'b1) begin
        last_ack = ov_ack_din;
        if (ov_ack_din[49:48] == 2'b10) nak_seen++;
      end
      check(ov_dup_cnt === m_dup, "dup_cnt", 64'(ov_dup_cnt), 64'(m_dup));
      check(ov_oos_cnt === m_oos, "oos_cnt", 64'(ov_oos_cnt), 64'(m_oos));
      if (o_packet_out_valid === 1'b1) begin
        if (beat_q.size() == 0) check(1'b0, "unexpected_out_beat", 64'(ov_packet_out_data), 64'd0);
        else begin
          b = beat_q.pop_front();
          check(ov_packet_out_head === b.head, "out_head", ov_packet_out_head[63:0], b.head[63:0]);
          check(ov_packet_out_data === b.data, "out_data", ov_packet_out_data, b.data);
          check(o_packet_out_start === b.s && o_packet_out_last === b.l, "out_start_last",
                64'({o_packet_out_start, o_packet_out_last}), 64'({b.s, b.l}));
          if (o_packet_out_start) last_head_lo = ov_packet_out_head[7:0];
        end
      end
      lhs = i_packet_in_valid && o_packet_in_ready && i_packet_in_last;
      pend_ack = 1'b0;
      if (lhs && !rst) begin
        if (pkt_q.size() == 0) check(1'b0, "unexpected_pkt_end", 64'(o_epsn_wr_en), 64'd0);
        else begin
          r = pkt_q.pop_front();
          check(o_epsn_wr_en === r.wr, "epsn_wr_en", 64'(o_epsn_wr_en), 64'(r.wr));
          if (r.wr) check(ov_epsn_wr_index === r.idx && ov_epsn_wr_data === r.wdata, "epsn_wr",
                          64'({ov_epsn_wr_index, ov_epsn_wr_data}), 64'({r.idx, r.wdata}));
          pend_ack  = r.ack;
          pend_ackv = r.ackv;
          if (r.dup) m_dup++;
          if (r.oos) m_oos++;
        end
      end else begin
        check(o_epsn_wr_en === 1'b0, "epsn_wr_quiet", 64'(o_epsn_wr_en), 64'd0);
      end
      if (rst) begin
        m_dup = '0; m_oos = '0; pend_ack = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one packet, registering its expected effects first. abort_beat != 0 pulses rst with that beat (1-based).
  task automatic send_pkt(input int qpn, input logic [23:0] psn, input logic [2:0] svc, input int nbeats,
                          input bit toggle, input int full_cycles, input int abort_beat);
    logic [HEAD_W-1:0] head, exp_head;
    logic [23:0] e, d;
    pkt_rec_t r;
    beat_t bt;
    bit fwd;
    int n;
    pkt_id++;
    head = '0;
    head[HEAD_W-1:272] = '1;
    head[271:248] = psn;
    head[QPN_OFS +: 24] = 24'(qpn);
    head[SVC_OFS +: 3] = svc;
    head[200:8] = {3{64'h5A3C_9612_F00D_BEEF}};
    head[7:0] = 8'h0F;
    e = m_epsn[qpn];
    d = psn - e;
    r = '{wr: 0, idx: 4'(qpn), wdata: psn + 24'd1, ack: 0, ackv: '0, dup: 0, oos: 0};
    fwd = 0;
    if (svc == RC) begin
      if (d == 24'd0) begin
        fwd = 1; r.wr = 1; r.ack = 1; r.ackv = {2'b01, psn, 24'(qpn)};
      end else if (d < 24'h800000) begin
        r.oos = 1; r.ackv = {2'b10, e, 24'(qpn)};
`ifdef INORDER_ACCEPT_NAK_ONCE_EN
        r.ack = !m_nak[qpn];
`else
        r.ack = 1;
`endif
      end else begin
        r.dup = 1; r.ack = 1; r.ackv = {2'b01, e - 24'd1, 24'(qpn)};
      end
    end else if (svc == UC) begin
      fwd = 1; r.wr = 1;
    end else if (svc == UD) begin
      fwd = 1;
    end
    if (abort_beat == 0) begin
      pkt_q.push_back(r);
      if (r.wr) m_epsn[qpn] = r.wdata;
      if (svc == RC && d == 24'd0) m_nak[qpn] = 0;
      if (r.oos) m_nak[qpn] = 1;
    end
    exp_head = '0;
    exp_head[247:8] = head[247:8];
    exp_head[7:0] = head[7:0] - 8'd3;
    for (int b = 0; b < nbeats; b++) begin
      if (fwd && (abort_beat == 0 || b < abort_beat)) begin
        bt.head = (b == 0) ? exp_head : '0;
        bt.data = {8'(pkt_id), 8'(b), 48'hC0DE_0000_1234};
        bt.s = (b == 0);
        bt.l = (b == nbeats - 1);
        beat_q.push_back(bt);
      end
    end
    for (int b = 0; b < nbeats; b++) begin
      i_packet_in_valid = 1'b1;
      iv_packet_in_head = (b == 0) ? head : ~head;
      iv_packet_in_data = {8'(pkt_id), 8'(b), 48'hC0DE_0000_1234};
      i_packet_in_start = (b == 0);
      i_packet_in_last  = (b == nbeats - 1);
      if (b == 0 && full_cycles > 0) begin
        i_ack_prog_full = 1'b1;
        repeat (full_cycles) begin
          @(negedge clk);
          check(o_packet_in_ready === 1'b0 && o_packet_out_valid === 1'b0, "full_stall",
                64'({o_packet_in_ready, o_packet_out_valid}), 64'd0);
          check(ov_epsn_rd_index === 4'(qpn), "full_rd_index", 64'(ov_epsn_rd_index), 64'(qpn));
          @(posedge clk); #1;
        end
        i_ack_prog_full = 1'b0;
      end
      if (abort_beat != 0 && b == abort_beat - 1) rst = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        if (o_packet_in_ready) break;
        n++;
        if (n > 200) begin
          check(1'b0, "handshake_timeout", 64'(n), 64'd0);
          i_packet_in_valid = 1'b0;
          return;
        end
        @(posedge clk); #1;
        if (toggle) i_packet_out_ready = ~i_packet_out_ready;
      end
      @(posedge clk); #1;
      if (toggle) i_packet_out_ready = ~i_packet_out_ready;
      if (rst) begin
        rst = 1'b0;
        m_nak = '0;
        i_packet_in_start = 1'b0;
        i_packet_in_last  = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check(o_packet_in_ready === 1'b0 && o_packet_out_valid === 1'b0 && o_ack_wr_en === 1'b0,
                "post_reset_quiet", 64'({o_packet_in_ready, o_packet_out_valid, o_ack_wr_en}), 64'd0);
          @(posedge clk); #1;
        end
        break;
      end
    end
    i_packet_in_valid = 1'b0;
    i_packet_in_start = 1'b0;
    i_packet_in_last  = 1'b0;
    i_packet_out_ready = 1'b1;
  endtask

  initial begin
    i_packet_in_valid = 0; iv_packet_in_head = '0; iv_packet_in_data = '0;
    i_packet_in_start = 0; i_packet_in_last = 0; i_ack_prog_full = 0; i_packet_out_ready = 1;
    for (int q = 0; q < 16; q++) begin
      logic [23:0] v;
      v = 24'(q * 24'h111);
      if (q == 5 || q == 6 || q == 8) v = 24'h10;
      if (q == 7) v = 24'hFFFFFF;
      if (q == 9) v = 24'h100;
      m_epsn[q] = v;
      @(posedge clk); #1;
      tb_wr = 1; tb_idx = 4'(q); tb_data = v;
    end
    @(posedge clk); #1;
    tb_wr = 0;
    @(negedge clk);
    check(o_packet_in_ready === 1'b0 && o_packet_out_valid === 1'b0 && o_epsn_wr_en === 1'b0 && o_ack_wr_en === 1'b0,
          "reset_outputs", 64'({o_packet_in_ready, o_packet_out_valid, o_epsn_wr_en, o_ack_wr_en}), 64'd0);
    check(ov_dup_cnt === 32'd0 && ov_oos_cnt === 32'd0 && ov_ack_din === '0, "reset_counters",
          64'({ov_dup_cnt, ov_oos_cnt}), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    chk_en = 1;

    send_pkt(5, 24'h10, RC, 3, 0, 0, 0); idle(3);
    $display("pkt rc in-order qpn5 psn 0x10: epsn=0x%0h ack=0x%0h", epsn_mem[5], last_ack);
    check(epsn_mem[5] === 24'h11, "lit_epsn5", 64'(epsn_mem[5]), 64'h11);
    check(last_ack === {2'b01, 24'h10, 24'd5}, "lit_ack_inorder", 64'(last_ack), 64'({2'b01, 24'h10, 24'd5}));
    check(last_head_lo === 8'h0C, "lit_head_len", 64'(last_head_lo), 64'h0C);

    send_pkt(6, 24'h0E, RC, 2, 0, 0, 0); idle(3);
    $display("pkt rc duplicate qpn6 psn 0x0E: dup_cnt=%0d ack=0x%0h", ov_dup_cnt, last_ack);
    check(last_ack === {2'b01, 24'h0F, 24'd6}, "lit_ack_dup", 64'(last_ack), 64'({2'b01, 24'h0F, 24'd6}));
    check(ov_dup_cnt === 32'd1, "lit_dup_cnt", 64'(ov_dup_cnt), 64'd1);
    check(epsn_mem[6] === 24'h10, "lit_epsn6_kept", 64'(epsn_mem[6]), 64'h10);

    send_pkt(8, 24'h14, RC, 2, 0, 0, 0); idle(2);
    send_pkt(8, 24'h14, RC, 1, 0, 0, 0); idle(2);
    send_pkt(8, 24'h10, RC, 2, 0, 0, 0); idle(2);
    send_pkt(8, 24'h14, RC, 1, 0, 0, 0); idle(3);
    $display("pkts rc oos qpn8: naks=%0d oos_cnt=%0d epsn=0x%0h", nak_seen, ov_oos_cnt, epsn_mem[8]);
`ifdef INORDER_ACCEPT_NAK_ONCE_EN
    check(nak_seen == 2, "lit_nak_count", 64'(nak_seen), 64'd2);
`else
    check(nak_seen == 3, "lit_nak_count", 64'(nak_seen), 64'd3);
`endif
    check(ov_oos_cnt === 32'd3, "lit_oos_cnt", 64'(ov_oos_cnt), 64'd3);
    check(last_ack === {2'b10, 24'h11, 24'd8}, "lit_nak_val", 64'(last_ack), 64'({2'b10, 24'h11, 24'd8}));

    send_pkt(7, 24'hFFFFFF, RC, 2, 0, 0, 0); idle(2);
    $display("pkt rc wrap qpn7 psn 0xFFFFFF: epsn=0x%0h", epsn_mem[7]);
    check(epsn_mem[7] === 24'h0, "lit_epsn_wrap", 64'(epsn_mem[7]), 64'h0);
    send_pkt(7, 24'h000000, RC, 1, 0, 0, 0); idle(2);
    $display("pkt rc after wrap qpn7 psn 0x0: epsn=0x%0h", epsn_mem[7]);
    check(epsn_mem[7] === 24'h1, "lit_epsn_after_wrap", 64'(epsn_mem[7]), 64'h1);

    send_pkt(5, 24'h11, RC, 5, 1, 4, 0); idle(2);
    $display("pkt rc stalled+toggled qpn5 psn 0x11: epsn=0x%0h", epsn_mem[5]);
    send_pkt(5, 24'h12, RC, 1, 0, 0, 0); idle(2);
    $display("pkt rc single-beat qpn5 psn 0x12: epsn=0x%0h", epsn_mem[5]);
    check(epsn_mem[5] === 24'h13, "lit_epsn5_single", 64'(epsn_mem[5]), 64'h13);

    send_pkt(9, 24'h55, UC, 2, 0, 0, 0); idle(2);
    $display("pkt uc qpn9 psn 0x55: epsn=0x%0h", epsn_mem[9]);
    check(epsn_mem[9] === 24'h56, "lit_uc_resync", 64'(epsn_mem[9]), 64'h56);
    send_pkt(10, 24'h77, UD, 2, 1, 0, 0); idle(2);
    $display("pkt ud qpn10: epsn=0x%0h", epsn_mem[10]);
    send_pkt(11, 24'h99, RD, 2, 0, 0, 0); idle(2);
    $display("pkt other-service qpn11: dropped, epsn=0x%0h", epsn_mem[11]);
    check(epsn_mem[11] === 24'(11 * 24'h111), "lit_other_no_wr", 64'(epsn_mem[11]), 64'(11 * 24'h111));

    send_pkt(5, 24'h13, RC, 4, 0, 0, 2); idle(2);
    $display("pkt rc aborted by reset qpn5: epsn=0x%0h dup=%0d oos=%0d", epsn_mem[5], ov_dup_cnt, ov_oos_cnt);
    check(epsn_mem[5] === 24'h13, "lit_abort_no_wr", 64'(epsn_mem[5]), 64'h13);
    check(ov_dup_cnt === 32'd0 && ov_oos_cnt === 32'd0, "lit_abort_cnt_clr", 64'({ov_dup_cnt, ov_oos_cnt}), 64'd0);
    send_pkt(12, 24'h5, UD, 2, 0, 0, 0); idle(3);
    $display("pkt ud after reset qpn12: epsn=0x%0h", epsn_mem[12]);

    check(beat_q.size() == 0 && pkt_q.size() == 0, "queues_drained", 64'({beat_q.size(), pkt_q.size()}), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0t expected finish", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/in_order_accept.md
Name: in_order_accept

Overview:
- Receive-side in-order checker of the transport subsystem; counterpart of the send-side PSN injector.
- Takes packets from the network parser, reads the per-QP expected PSN (EPSN) and classifies RC packets as in-order, duplicate or out-of-sequence.
- Forwards in-order packets to the ULP with the transport prefix stripped, drops the others, updates EPSN and pushes ACK/NAK commands to the response generator.
- UC and UD packets bypass the sequence check.

Parameters:
- HEAD_W, `PKT_HEAD_WIDTH, packet header bus width
- DATA_W, `PKT_DATA_WIDTH, packet data bus width
- QPN_LOG, `QP_NUM_LOG, EPSN table index width
- PSN_W, `PSN_WIDTH (24), PSN width
- ACK_CMD_W, 50, ACK command width: {type[1:0], psn[23:0], qpn[23:0]}

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_packet_in_valid  in  1  input beat valid
- iv_packet_in_head  in  HEAD_W  header, meaningful on start beat; PSN at [271:248], QPN at `QPN_OFFSET, service type at `SERVICE_TYPE_OFFSET, header length at [7:0]
- iv_packet_in_data  in  DATA_W  payload beat
- i_packet_in_start  in  1  first beat
- i_packet_in_last  in  1  last beat
- o_packet_in_ready  out  1  input beat accepted when valid&&ready
- ov_epsn_rd_index  out  QPN_LOG  EPSN table read index
- iv_epsn_rd_data  in  PSN_W  EPSN read data, combinational
- o_epsn_wr_en  out  1  EPSN write strobe
- ov_epsn_wr_index  out  QPN_LOG  EPSN write index
- ov_epsn_wr_data  out  PSN_W  EPSN write data
- o_ack_wr_en  out  1  ACK command FIFO push
- ov_ack_din  out  ACK_CMD_W  ACK command
- i_ack_prog_full  in  1  ACK FIFO programmable full
- o_packet_out_valid / ov_packet_out_head / ov_packet_out_data / o_packet_out_start / o_packet_out_last  out  1/HEAD_W/DATA_W/1/1  packet to ULP
- i_packet_out_ready  in  1  downstream ready
- ov_dup_cnt  out  32  duplicate-drop counter
- ov_oos_cnt  out  32  out-of-sequence-drop counter

Behaviour:
- Reset (synchronous): state IDLE; all outputs 0; counters 0; all latched fields 0. A reset mid-packet abandons the packet; the remainder is not consumed until a new start beat arrives.
- ov_epsn_rd_index: header QPN low bits in IDLE, latched QPN otherwise.
- States:
  - IDLE:
    - o_packet_in_ready = 0.
    - On valid && start && !i_ack_prog_full, latch QPN (24 b), PSN, EPSN and class, then go to FWD or DROP.
    - The start beat stays on the bus, so there is a 1-cycle bubble per packet.
  - FWD:
    - o_packet_in_ready = i_packet_out_ready.
    - out_valid = in_valid && i_packet_out_ready; data, start and last pass through.
    - On the start beat, out head = {zeros, head[247:8], head[7:0] - 8'd3}; PSN removed, length restored. Out head is 0 on other beats.
    - Last-beat handshake -> IDLE.
  - DROP:
    - o_packet_in_ready = 1; out_valid = 0.
    - Last-beat handshake -> IDLE.
- Classification (diff = (PSN - EPSN) mod 2^24):
  - RC, diff == 0: in-order -> FWD.
  - RC, 1 <= diff <= 2^23-1: out-of-sequence -> DROP.
  - RC, diff >= 2^23: duplicate -> DROP.
  - UC: FWD regardless of PSN.
  - UD: FWD.
  - Other service types: DROP, no EPSN write, no ACK.
- EPSN write: combinational, asserted in the cycle of the last-beat handshake.
  - RC in-order: data = PSN + 1.
  - UC: data = PSN + 1 (resync).
  - UD, duplicate, OOS: no write.
  - Arithmetic wraps at 2^24 (0xFFFFFF + 1 = 0).
- ACK push: registered, o_ack_wr_en pulses 1 cycle after the last-beat handshake; RC only.
  - In-order: {2'b01, PSN, QPN}.
  - Duplicate: {2'b01, EPSN - 1, QPN}.
  - OOS: {2'b10, EPSN, QPN}.
  - i_ack_prog_full is checked only in IDLE; its headroom covers the one command already in flight.
- Back-to-back packets on the same QP: the write lands at the clock edge ending the packet, so the next IDLE read sees the updated EPSN.
- Counters: ov_dup_cnt and ov_oos_cnt increment on the last-beat handshake of the corresponding drop; they saturate at 0xFFFFFFFF.
- Single-beat packet (start && last): handled as a normal packet, start-beat header rewrite included.

Optional Feature:
- Macro: INORDER_ACCEPT_NAK_ONCE_EN.
- Defined:
  - Adds a per-QP nak_sent bitmap (2^QPN_LOG bits, cleared by reset).
  - On an OOS packet, a NAK is pushed only if the QP's bit is 0, and the bit is then set.
  - An RC in-order packet clears the bit.
  - ov_oos_cnt still counts every OOS drop.
- Undefined: every OOS packet produces a NAK.

Test Plan:
- RC, QPN 5, EPSN 0x10, PSN 0x10, 3 beats -> 3 beats forwarded, head[7:0] 0x0F in -> 0x0C out; EPSN[5] = 0x11; ACK {01, 0x10, 5} one cycle after last.
- RC, EPSN 0x10, PSN 0x0E -> dropped with ready held 1; ACK {01, 0x0F, 5}; ov_dup_cnt = 1; EPSN unchanged.
- RC, EPSN 0x10, PSN 0x14 sent twice -> both dropped; without macro 2 NAKs {10, 0x10, 5}, with macro 1 NAK; then PSN 0x10 -> forwarded, bit cleared.
- Wrap case: EPSN 0xFFFFFF, PSN 0xFFFFFF -> EPSN written 0x000000; then PSN 0x000000 -> in-order.
- i_ack_prog_full = 1 with an RC start beat valid -> ready stays 0 and no state change until full deasserts; i_packet_out_ready toggling mid-FWD -> no beat lost or duplicated.
- Assert rst mid-FWD on beat 2 of 4 -> next cycle in IDLE with outputs 0 and no EPSN write or ACK; UD packet afterwards -> forwarded with no EPSN write or ACK.
